// File: rtl/ucomb_full_core.sv
// ----------------------------------------------------------------------------
// ucomb_full_core
//
// Universal combinational cell for the unigate fabric. It evaluates a
// programmable 4-input Boolean function (a 16-entry truth table built from a
// two-level tree of 4:1 selectors) plus five detect/parity flags over a 4-bit
// wiring word.
//
// Ports:
//   clk    in   1   clock; only used when the output register is compiled in
//   rst_n  in   1   asynchronous active-low reset of the output register
//   in     in  27   in[3:0]  = wiring word w
//                   in[26:4] = configuration c[22:0]
//   out    out  6   [0] T[w] ^ c[16]
//                   [1] high-pair match, enabled by c[17]
//                   [2] low-pair match, enabled by c[22]
//                   [3] out[0] & out[2]
//                   [4] full 4-bit pattern match (out[1] & out[2])
//                   [5] parity of w
//
// Build option:
//   UCOMB_OUT_REG_EN  defined   -> out is a 6-bit register, 1-cycle latency,
//                                  cleared asynchronously while rst_n is low
//                     undefined -> out is purely combinational; clk and rst_n
//                                  stay on the port list but are ignored
// ----------------------------------------------------------------------------

// 4:1 selector leaf: out = data[sel], sel = 0 picks data[0].
module ucomb_mux2 (
  input  logic [3:0] data,
  input  logic [1:0] sel,
  output logic       y
);
  // Plain indexing keeps X/Z on sel visible in simulation.
  assign y = data[sel];
endmodule

module ucomb_full_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] in,
  output logic [5:0]  out
);

  logic [3:0]  w;
  logic [22:0] c;

  assign w = in[3:0];
  assign c = in[26:4];

  // --------------------------------------------------------------------------
  // Truth-table lookup: four leaves each resolve one nibble of T with w[1:0],
  // the root picks one leaf result with w[3:2].
  // --------------------------------------------------------------------------
  logic [3:0] leaf_y;
  logic       table_bit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_leaf
      ucomb_mux2 u_leaf (
        .data (c[4*gi+3:4*gi]),
        .sel  (w[1:0]),
        .y    (leaf_y[gi])
      );
    end
  endgenerate

  ucomb_mux2 u_root (
    .data (leaf_y),
    .sel  (w[3:2]),
    .y    (table_bit)
  );

  // --------------------------------------------------------------------------
  // Flag logic (pre-register values)
  // --------------------------------------------------------------------------
  logic       func_bit;
  logic       hi_match;
  logic       lo_match;
  logic       parity_bit;
  logic [5:0] out_next;

  assign func_bit   = table_bit ^ c[16];
  assign hi_match   = c[17] & (w[3:2] == c[21:20]);
  assign lo_match   = c[22] & (w[1:0] == c[19:18]);
  assign parity_bit = ^w;

  assign out_next = {parity_bit,
                     hi_match & lo_match,
                     func_bit & lo_match,
                     lo_match,
                     hi_match,
                     func_bit};

  // --------------------------------------------------------------------------
  // Optional output register
  // --------------------------------------------------------------------------
`ifdef UCOMB_OUT_REG_EN
  logic [5:0] out_reg;

  // Reset is asynchronous: out clears the moment rst_n falls, and the first
  // capture is the first rising edge that sees rst_n already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= 6'b000000;
    end else begin
      out_reg <= out_next;
    end
  end

  assign out = out_reg;
`else
  // Combinational build: clk and rst_n are intentionally ignored.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

  assign out = out_next;
`endif

endmodule

// File: tb/tb_ucomb_full_core.sv
// ----------------------------------------------------------------------------
// Testbench for ucomb_full_core. Works for both builds: stimulus is applied on
// the falling edge and sampled 1 ns after the following rising edge, where the
// registered and combinational builds present the same value. Register-only
// behaviour (latency, asynchronous clear) is checked when UCOMB_OUT_REG_EN is
// defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ucomb_full_core;

  logic        clk;
  logic        rst_n;
  logic [26:0] in_bus;
  logic [5:0]  out_bus;

  int n_cmp;
  int n_err;

  ucomb_full_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_bus),
    .out   (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the flag definitions, using arithmetic.
  function automatic logic [5:0] model(input logic [22:0] c, input logic [3:0] w);
    logic [15:0] t;
    logic        f, hm, lm, p;
    int          wi;
    wi = int'(w);
    t  = c[15:0];
    f  = ((t >> wi) & 16'd1) != 16'd0;
    f  = f ^ c[16];
    hm = c[17] && ((wi / 4) == int'(c[21:20]));
    lm = c[22] && ((wi % 4) == int'(c[19:18]));
    p  = ($countones(w) % 2) == 1;
    return {p, hm & lm, f & lm, lm, hm, f};
  endfunction

  // Apply on the falling edge, then wait until just after the next capture.
  task automatic apply(input logic [22:0] c, input logic [3:0] w);
    @(negedge clk);
    in_bus = {c, w};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] c;
    logic [3:0]  w;
    logic [5:0]  exp;
    c = 23'h5A5A5A;
    w = 4'b0110;
    @(negedge clk);
    rst_n  = 1'b0;
    in_bus = {c, w};
    #1;
`ifdef UCOMB_OUT_REG_EN
    exp = 6'd0;
`else
    exp = model(c, w);
`endif
    n_cmp++;
    if (out_bus !== exp) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", out_bus, exp);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_bus !== exp) begin
      n_err++;
      $display("FAIL reset_over_edge: got %b want %b", out_bus, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp = model(c, w);
    n_cmp++;
    if (out_bus !== exp) begin
      n_err++;
      $display("FAIL reset_first_capture: got %b want %b", out_bus, exp);
    end
    $display("test_reset: first capture out=%b", out_bus);
  endtask

  task automatic test_directed();
    logic [22:0] c;
    c = 23'b10011000000000000000100;
    apply(c, 4'b0011);
    n_cmp++;
    if (out_bus !== 6'd4) begin
      n_err++;
      $display("FAIL default_w0011: got %b want %b", out_bus, 6'd4);
    end
    $display("directed cfg=%h w=0011 out=%b", c, out_bus);
    apply(c, 4'b0010);
    n_cmp++;
    if (out_bus !== 6'b100001) begin
      n_err++;
      $display("FAIL default_w0010: got %b want %b", out_bus, 6'b100001);
    end
    $display("directed cfg=%h w=0010 out=%b", c, out_bus);
  endtask

  task automatic test_truth_sweep();
    logic [22:0] c;
    logic        exp0;
    int          errs_before;
    errs_before = n_err;
    for (int inv = 0; inv < 2; inv++) begin
      for (int k = 0; k < 16; k++) begin
        for (int w = 0; w < 16; w++) begin
          c = 23'd0;
          c[15:0] = 16'd1 << k;
          c[16]   = (inv == 1);
          apply(c, 4'(w));
          exp0 = (w == k) ^ (inv == 1);
          n_cmp++;
          if (out_bus[0] !== exp0) begin
            n_err++;
            $display("FAIL truth_sweep inv=%0d k=%0d w=%0d: got %b want %b",
                     inv, k, w, out_bus[0], exp0);
          end
        end
      end
    end
    $display("test_truth_sweep: 512 lookups, %0d errors", n_err - errs_before);
  endtask

  task automatic test_full_match();
    logic [22:0] c;
    c = 23'd0;
    c[15:0]  = 16'hFFFF;
    c[17]    = 1'b1;
    c[22]    = 1'b1;
    c[21:20] = 2'b10;
    c[19:18] = 2'b01;
    apply(c, 4'b1001);
    n_cmp++;
    if (out_bus !== 6'b011111) begin
      n_err++;
      $display("FAIL full_match: got %b want %b", out_bus, 6'b011111);
    end
    $display("full_match cfg=%h w=1001 out=%b", c, out_bus);
    // Same pattern with the high pair disabled: only the low match survives.
    c[17] = 1'b0;
    apply(c, 4'b1001);
    n_cmp++;
    if (out_bus !== 6'b001101) begin
      n_err++;
      $display("FAIL full_match_hi_off: got %b want %b", out_bus, 6'b001101);
    end
    $display("full_match_hi_off cfg=%h w=1001 out=%b", c, out_bus);
  endtask

  task automatic test_random();
    logic [22:0] c;
    logic [3:0]  w;
    logic [5:0]  exp;
    for (int i = 0; i < 300; i++) begin
      c = 23'($urandom);
      w = 4'($urandom_range(0, 15));
      // Bias half the vectors so the match flags are frequently exercised.
      if (i % 2 == 0) begin
        c[17] = 1'b1;
        c[22] = 1'b1;
        c[21:20] = w[3:2];
        if (i % 4 == 0) c[19:18] = w[1:0];
      end
      apply(c, w);
      exp = model(c, w);
      n_cmp++;
      if (out_bus !== exp) begin
        n_err++;
        $display("FAIL random[%0d] cfg=%h w=%b: got %b want %b", i, c, w, out_bus, exp);
      end
      if (i % 50 == 0) $display("random[%0d] cfg=%h w=%b out=%b", i, c, w, out_bus);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] c [8];
    logic [3:0]  w [8];
    logic [5:0]  exp;
    for (int i = 0; i < 8; i++) begin
      c[i] = 23'($urandom);
      c[i][22] = 1'b1;
      c[i][17] = 1'b1;
      w[i] = 4'(i * 5 + 3);
    end
    @(negedge clk);
    in_bus = {c[0], w[0]};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      exp = model(c[i], w[i]);
      n_cmp++;
      if (out_bus !== exp) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, out_bus, exp);
      end
      $display("back_to_back[%0d] w=%b out=%b", i, w[i], out_bus);
      @(negedge clk);
      if (i < 7) in_bus = {c[i+1], w[i+1]};
    end
  endtask

`ifdef UCOMB_OUT_REG_EN
  task automatic test_latency();
    logic [22:0] c;
    logic [5:0]  old_v, new_v;
    c = 23'b10011000000000000000100;
    apply(c, 4'b0011);
    old_v = model(c, 4'b0011);
    new_v = model(c, 4'b0010);
    @(negedge clk);
    in_bus = {c, 4'b0010};
    #1;
    n_cmp++;
    if (out_bus !== old_v) begin
      n_err++;
      $display("FAIL latency_hold: got %b want %b", out_bus, old_v);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_bus !== new_v) begin
      n_err++;
      $display("FAIL latency_update: got %b want %b", out_bus, new_v);
    end
    // Mid-cycle asynchronous clear.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_bus !== 6'd0) begin
      n_err++;
      $display("FAIL midcycle_reset: got %b want %b", out_bus, 6'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_bus !== new_v) begin
      n_err++;
      $display("FAIL after_midcycle_reset: got %b want %b", out_bus, new_v);
    end
    $display("test_latency: old=%b new=%b final out=%b", old_v, new_v, out_bus);
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    in_bus = 27'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_truth_sweep();
    test_full_match();
    test_random();
    test_back_to_back();
`ifdef UCOMB_OUT_REG_EN
    test_latency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
